// File: rtl/led_rgb_pwm_driver.sv
// RGB PWM driver: samples colour code and duty only at period boundaries so the
// channel outputs never glitch mid-period; illegal codes 000/111 park it in FAULT.
module led_pwm_chan #(
  parameter int W = 8
) (
  input  logic         run_i,
  input  logic         en_i,
  input  logic [W-1:0] cnt_i,
  input  logic [W-1:0] duty_i,
  output logic         drive_o
);
  assign drive_o = run_i & en_i & (cnt_i < duty_i);
endmodule

module led_rgb_pwm_driver #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [2:0]          colour,
  input  logic [PWM_BITS-1:0] duty,
  output logic                red,
  output logic                green,
  output logic                blue,
  output logic                period_start,
  output logic                fault,
  output logic                fault_seen
);
  localparam int NUM_LANES = 3;

  typedef enum logic [1:0] {IDLE, RUN, FAULT} state_e;

  state_e                state_q, state_d;
  logic [PWM_BITS-1:0]   cnt_q, cnt_d;
  logic [2:0]            colour_q, colour_d;
  logic [PWM_BITS-1:0]   duty_q, duty_d;
  logic                  fault_seen_q, fault_seen_d;
  logic                  boundary, illegal;
  logic [NUM_LANES-1:0]  drv;

  // IDLE samples on the very first enabled edge; RUN/FAULT only at end of period.
  assign boundary = (state_q == IDLE) || (cnt_q == {PWM_BITS{1'b1}});
  assign illegal  = (colour == 3'b000) || (colour == 3'b111);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    colour_d     = colour_q;
    duty_d       = duty_q;
    fault_seen_d = fault_seen_q;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (boundary) begin
      colour_d = colour;
      duty_d   = duty;
      cnt_d    = '0;
      state_d  = illegal ? FAULT : RUN;
      if (illegal) fault_seen_d = 1'b1;
    end else begin
      cnt_d = cnt_q + PWM_BITS'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      colour_q     <= 3'b000;
      duty_q       <= '0;
      fault_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      colour_q     <= colour_d;
      duty_q       <= duty_d;
      fault_seen_q <= fault_seen_d;
    end
  end

  // Lane i drives colour bit i: lane 2 red, lane 1 green, lane 0 blue.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_chan
    led_pwm_chan #(.W(PWM_BITS)) u_chan (
      .run_i   (state_q == RUN),
      .en_i    (colour_q[i]),
      .cnt_i   (cnt_q),
      .duty_i  (duty_q),
      .drive_o (drv[i])
    );
  end

  assign {red, green, blue} = drv;
  assign period_start       = (state_q != IDLE) && (cnt_q == '0);
  assign fault              = (state_q == FAULT);
  assign fault_seen         = fault_seen_q;
endmodule
